// File: rtl/streaming_fifo_pkg.sv
// Shared helpers for the streaming FIFO: count width derivation and parameter sanity checks.
package streaming_fifo_pkg;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int unsigned value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// DEPTH x WIDTH simple dual-port storage with one write port and one registered read port.
module stream_fifo_ram #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    input  logic             fwd_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // fwd_i loads the word being written this edge, used when it becomes the new head.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= fwd_i ? wdata_i : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/streaming_fifo_hwm.sv
// AXI-Stream FWFT FIFO with exact-width occupancy count, clearable high-water mark and
// registered almost-full/almost-empty flags.
module streaming_fifo_hwm
    import streaming_fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 12,
    parameter int unsigned AE_LEVEL = 2,
    localparam int unsigned CW      = cnt_width(DEPTH)
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic [WIDTH-1:0] in0_V_TDATA,
    input  logic             in0_V_TVALID,
    output logic             in0_V_TREADY,
    output logic [WIDTH-1:0] out_V_TDATA,
    output logic             out_V_TVALID,
    input  logic             out_V_TREADY,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    maxcount,
    input  logic             maxcount_clr,
    output logic             almost_full,
    output logic             almost_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("AF_LEVEL must lie in 1..DEPTH");
    end
    if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("AE_LEVEL must lie in 0..DEPTH-1");
    end

    logic [CW-1:0] count_q, count_d, maxcount_q, maxcount_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic          in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic          af_q, af_d, ae_q, ae_d;
    logic          push, pop, rd_en, rd_fwd;

    always_comb begin
        push        = in0_V_TVALID & in_ready_q;
        pop         = out_valid_q & out_V_TREADY;
        count_d     = count_q + CW'(push) - CW'(pop);
        wptr_d      = wptr_q + AW'(push);
        rptr_d      = rptr_q + AW'(pop);
        // The output register holds mem[rptr]; refill it whenever the head moves or is absent.
        rd_en       = pop | ~out_valid_q;
        // Nothing left in storage behind the head, so the new head is the word being pushed.
        rd_fwd      = (count_q == CW'(pop));
        in_ready_d  = (count_d < CW'(DEPTH));
        out_valid_d = (count_d != '0);
        af_d        = (count_d >= CW'(AF_LEVEL));
        ae_d        = (count_d <= CW'(AE_LEVEL));
        maxcount_d  = maxcount_q;
        if (maxcount_clr || (count_d > maxcount_q)) begin
            maxcount_d = count_d;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            count_q     <= '0;
            maxcount_q  <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
        end else begin
            count_q     <= count_d;
            maxcount_q  <= maxcount_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            af_q        <= af_d;
            ae_q        <= ae_d;
        end
    end

    stream_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (ap_clk),
        .we_i    (push),
        .waddr_i (wptr_q),
        .wdata_i (in0_V_TDATA),
        .re_i    (rd_en),
        .raddr_i (rptr_d),
        .fwd_i   (rd_fwd),
        .rdata_o (out_V_TDATA)
    );

    assign in0_V_TREADY = in_ready_q;
    assign out_V_TVALID = out_valid_q;
    assign count        = count_q;
    assign maxcount     = maxcount_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;

endmodule

// File: tb/tb_streaming_fifo_hwm.sv
// Directed bench for streaming_fifo_hwm: fill/drain vector table plus hand-written corner cases.
module tb_streaming_fifo_hwm;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    maxcnt;
    logic             clr;
    logic             af;
    logic             ae;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    streaming_fifo_hwm #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (12),
        .AE_LEVEL (2)
    ) dut (
        .ap_clk       (clk),
        .ap_rst_n     (rst_n),
        .in0_V_TDATA  (in_data),
        .in0_V_TVALID (in_valid),
        .in0_V_TREADY (in_ready),
        .out_V_TDATA  (out_data),
        .out_V_TVALID (out_valid),
        .out_V_TREADY (out_ready),
        .count        (cnt),
        .maxcount     (maxcnt),
        .maxcount_clr (clr),
        .almost_full  (af),
        .almost_empty (ae)
    );

    typedef struct {
        logic        in_valid;
        logic [31:0] in_data;
        logic        out_ready;
        int          exp_count;
        int          exp_max;
        logic        exp_in_ready;
        logic        exp_out_valid;
        logic        exp_af;
        logic        exp_ae;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[33];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] id, input logic ordy,
                         input logic c);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        clr       = c;
    endtask

    initial begin
        // Fill 0..15 with the output stalled.
        for (int k = 1; k <= 16; k++) begin
            vecs[k-1] = '{1'b1, 32'(k - 1), 1'b0, k, k, (k < 16), 1'b1,
                          (k >= 12), (k <= 2), 1'b1, 32'd0};
        end
        // Push attempt while full must be refused.
        vecs[16] = '{1'b1, 32'd99, 1'b0, 16, 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0};
        // Drain in order.
        for (int j = 1; j <= 16; j++) begin
            vecs[16+j] = '{1'b0, 32'd0, 1'b1, 16 - j, 16, 1'b1, (16 - j > 0),
                           (16 - j >= 12), (16 - j <= 2), (16 - j > 0), 32'(j)};
        end

        rst_n = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_count", 32'(cnt), 32'd0);
        chk("rst_max", 32'(maxcnt), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_af", 32'(af), 32'd0);
        chk("rst_ae", 32'(ae), 32'd1);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int v = 0; v < 33; v++) begin
            drive(vecs[v].in_valid, vecs[v].in_data, vecs[v].out_ready, 1'b0);
            tick();
            chk($sformatf("vec%0d_count", v), 32'(cnt), 32'(vecs[v].exp_count));
            chk($sformatf("vec%0d_max", v), 32'(maxcnt), 32'(vecs[v].exp_max));
            chk($sformatf("vec%0d_in_ready", v), 32'(in_ready), 32'(vecs[v].exp_in_ready));
            chk($sformatf("vec%0d_out_valid", v), 32'(out_valid), 32'(vecs[v].exp_out_valid));
            chk($sformatf("vec%0d_af", v), 32'(af), 32'(vecs[v].exp_af));
            chk($sformatf("vec%0d_ae", v), 32'(ae), 32'(vecs[v].exp_ae));
            if (vecs[v].chk_data) begin
                chk($sformatf("vec%0d_data", v), out_data, vecs[v].exp_data);
            end
        end

        // Streaming at count 8: words 100..207 through, order kept across pointer wraps.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(100 + i), 1'b0, 1'b0);
            tick();
        end
        chk("stream_prefill_count", 32'(cnt), 32'd8);
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 32'(108 + i), 1'b1, 1'b0);
            chk($sformatf("stream_data%0d", i), out_data, 32'(100 + i));
            tick();
            chk($sformatf("stream_count%0d", i), 32'(cnt), 32'd8);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 32'd0, 1'b1, 1'b0);
            chk($sformatf("stream_tail%0d", i), out_data, 32'(200 + i));
            tick();
        end
        chk("stream_end_count", 32'(cnt), 32'd0);
        chk("stream_end_valid", 32'(out_valid), 32'd0);

        // Empty-FIFO latency: one cycle to the output.
        drive(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
        chk("lat_pre_valid", 32'(out_valid), 32'd0);
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_data", out_data, 32'hA5A5_A5A5);
        chk("lat_count", 32'(cnt), 32'd1);

        // Pop at count 1 with simultaneous push.
        drive(1'b1, 32'h0000_005A, 1'b1, 1'b0);
        tick();
        chk("pp1_valid", 32'(out_valid), 32'd1);
        chk("pp1_data", out_data, 32'h0000_005A);
        chk("pp1_count", 32'(cnt), 32'd1);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        tick();
        chk("pp1_drained", 32'(out_valid), 32'd0);

        // High-water: clear at 0, climb to 10, drain to 3, clear with a push -> 4.
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        tick();
        chk("hwm_clr0", 32'(maxcnt), 32'd0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(300 + i), 1'b0, 1'b0);
            tick();
        end
        chk("hwm_max10", 32'(maxcnt), 32'd10);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 32'd0, 1'b1, 1'b0);
            tick();
        end
        chk("hwm_count3", 32'(cnt), 32'd3);
        chk("hwm_hold10", 32'(maxcnt), 32'd10);
        drive(1'b1, 32'd310, 1'b0, 1'b1);
        tick();
        chk("hwm_count4", 32'(cnt), 32'd4);
        chk("hwm_clr_push", 32'(maxcnt), 32'd4);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        chk("hwm_stay4", 32'(maxcnt), 32'd4);

        // Reset mid-stream at count 7, asserted between edges.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(400 + i), 1'b0, 1'b0);
            tick();
        end
        chk("mrst_count7", 32'(cnt), 32'd7);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_count", 32'(cnt), 32'd0);
        chk("mrst_max", 32'(maxcnt), 32'd0);
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        chk("mrst_ae", 32'(ae), 32'd1);
        tick();
        #3;
        rst_n = 1'b1;
        tick();
        chk("mrst_rel_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 32'h0000_0777, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0000_0778, 1'b0, 1'b0);
        chk("mrst_first_valid", 32'(out_valid), 32'd1);
        chk("mrst_first_data", out_data, 32'h0000_0777);
        tick();
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        chk("mrst_count2", 32'(cnt), 32'd2);
        tick();
        chk("mrst_second_data", out_data, 32'h0000_0778);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
